bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter; the inverse of the binary-to-BCD display path.

---
 rtl/bcd_to_bin.sv | 106 ++++++++++
 tb/tb_bcd_to_bin.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one bit per clock.
// States: IDLE wait for start | SHIFT shift + nibble correction | DONE one-cycle result pulse
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SR_W-1:0]    r_sreg;
  logic [SR_W-1:0]    w_shifted;
  logic [SR_W-1:0]    w_sreg_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic               r_err;
  logic               w_invalid;
  logic               w_last;

  always_comb begin
    w_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) w_invalid = 1'b1;
    end
  end

  // Shift right, then pull 3 off every BCD nibble that landed at 8 or above.
  always_comb begin
    w_shifted  = r_sreg >> 1;
    w_sreg_nxt = w_shifted;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_shifted[BIN_W + 4*i +: 4] >= 4'd8)
        w_sreg_nxt[BIN_W + 4*i +: 4] = w_shifted[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_invalid ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_invalid) begin
            r_bin <= '0;
            r_err <= 1'b1;
          end else if (start) begin
            r_sreg <= {bcd_in, {BIN_W{1'b0}}};
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_sreg <= w_sreg_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bin <= w_sreg_nxt[BIN_W-1:0];
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);
  assign bin_out = r_bin;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin at DIGITS=2, BIN_W=7.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       busy, done, err;
  logic [6:0] bin_out;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  // Pulses start with v; lat = edges from the sampling edge to the first edge that sees done.
  // lat stays 0 if done never shows up within the budget.
  task automatic run_conv(input logic [7:0] v, output int lat, output int bcnt,
                          output logic [6:0] bo, output logic e);
    lat = 0; bcnt = 0; bo = 'x; e = 1'bx;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 8'hFF;
      if (done) begin
        lat = n + 1;
        bo  = bin_out;
        e   = err;
        return;
      end
      bcnt += int'(busy);
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    vec++; if (busy !== 1'b0)    begin miss++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vec++; if (done !== 1'b0)    begin miss++; $display("FAIL reset_done got=%b exp=0", done); end
    vec++; if (bin_out !== 7'd0) begin miss++; $display("FAIL reset_bin got=%0d exp=0", bin_out); end
    vec++; if (err !== 1'b0)     begin miss++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt; logic [6:0] bo; logic e;
    run_conv(8'h42, lat, bcnt, bo, e);
    vec++; if (lat !== 8)      begin miss++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    vec++; if (bcnt !== 7)     begin miss++; $display("FAIL basic_busy_cycles got=%0d exp=7", bcnt); end
    vec++; if (bo !== 7'd42)   begin miss++; $display("FAIL basic_bin got=%0d exp=42", bo); end
    vec++; if (e !== 1'b0)     begin miss++; $display("FAIL basic_err got=%b exp=0", e); end
    vec++; if (busy !== 1'b0)  begin miss++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
    @(negedge clk);
    vec++; if (done !== 1'b0)  begin miss++; $display("FAIL basic_done_width got=%b exp=0", done); end
    vec++; if (bin_out !== 7'd42) begin miss++; $display("FAIL basic_hold got=%0d exp=42", bin_out); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic [6:0] bo; logic e;
    run_conv(8'h99, lat, bcnt, bo, e);
    vec++; if (lat !== 8 || bo !== 7'd99 || e !== 1'b0)
      begin miss++; $display("FAIL b2b_99 got lat=%0d bin=%0d err=%b exp lat=8 bin=99 err=0", lat, bo, e); end
    run_conv(8'h00, lat, bcnt, bo, e);
    vec++; if (lat !== 8 || bo !== 7'd0 || e !== 1'b0)
      begin miss++; $display("FAIL b2b_00 got lat=%0d bin=%0d err=%b exp lat=8 bin=0 err=0", lat, bo, e); end
    @(negedge clk);
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL b2b_done_width got=%b exp=0", done); end
  endtask

  task automatic test_invalid();
    int lat, bcnt; logic [6:0] bo; logic e;
    run_conv(8'hA5, lat, bcnt, bo, e);
    vec++; if (lat !== 1)    begin miss++; $display("FAIL inv_latency got=%0d exp=1", lat); end
    vec++; if (e !== 1'b1)   begin miss++; $display("FAIL inv_err got=%b exp=1", e); end
    vec++; if (bo !== 7'd0)  begin miss++; $display("FAIL inv_bin got=%0d exp=0", bo); end
    vec++; if (bcnt !== 0)   begin miss++; $display("FAIL inv_busy got=%0d exp=0", bcnt); end
    run_conv(8'h07, lat, bcnt, bo, e);
    vec++; if (lat !== 8 || bo !== 7'd7 || e !== 1'b0)
      begin miss++; $display("FAIL inv_recover got lat=%0d bin=%0d err=%b exp lat=8 bin=7 err=0", lat, bo, e); end
  endtask

  task automatic test_busy_ignore();
    int ndone; logic [6:0] bo; logic e;
    ndone = 0; bo = 'x; e = 1'bx;
    @(negedge clk);
    bcd_in = 8'h42;
    start  = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 2 || n == 3) begin start = 1'b1; bcd_in = 8'h13; end
      if (done) begin
        ndone++;
        bo = bin_out;
        e  = err;
        start  = 1'b1;
        bcd_in = 8'h13;
      end
    end
    vec++; if (ndone !== 1)   begin miss++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    vec++; if (bo !== 7'd42)  begin miss++; $display("FAIL ignore_bin got=%0d exp=42", bo); end
    vec++; if (e !== 1'b0)    begin miss++; $display("FAIL ignore_err got=%b exp=0", e); end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bcnt; logic [6:0] bo; logic e;
    ndone = 0;
    @(negedge clk);
    bcd_in = 8'h42;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    vec++; if (busy !== 1'b0)    begin miss++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    vec++; if (done !== 1'b0)    begin miss++; $display("FAIL rstmid_done got=%b exp=0", done); end
    vec++; if (bin_out !== 7'd0) begin miss++; $display("FAIL rstmid_bin got=%0d exp=0", bin_out); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    vec++; if (ndone !== 0) begin miss++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    run_conv(8'h58, lat, bcnt, bo, e);
    vec++; if (lat !== 8 || bo !== 7'd58 || e !== 1'b0)
      begin miss++; $display("FAIL rstmid_next got lat=%0d bin=%0d err=%b exp lat=8 bin=58 err=0", lat, bo, e); end
  endtask

  task automatic test_sweep();
    int lat, bcnt; logic [6:0] bo; logic e; logic [6:0] exp_v; logic [7:0] code;
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        code  = {4'(t), 4'(o)};
        exp_v = 7'(t*10 + o);
        run_conv(code, lat, bcnt, bo, e);
        vec++; if (lat !== 8 || bo !== exp_v || e !== 1'b0)
          begin miss++; $display("FAIL sweep_%h got lat=%0d bin=%0d err=%b exp lat=8 bin=%0d err=0", code, lat, bo, e, exp_v); end
      end
    end
    for (int c = 0; c < 256; c++) begin
      code = 8'(c);
      if (code[7:4] > 4'd9 || code[3:0] > 4'd9) begin
        run_conv(code, lat, bcnt, bo, e);
        vec++; if (lat !== 1 || bo !== 7'd0 || e !== 1'b1)
          begin miss++; $display("FAIL sweep_inv_%h got lat=%0d bin=%0d err=%b exp lat=1 bin=0 err=1", code, lat, bo, e); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_busy_ignore();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
